seq_gen_1101: RTL
=================

Name: seq_gen_1101

Overview:
Moore-style serial pattern transmitter that produces the 1101 bitstream consumed by the team's 1101 sequence detectors. On a start request it emits a programmable number of 1101 frames, one bit per clock. Frames are either back-to-back, overlapped (frames share the trailing/leading 1) or separated by a programmable zero gap. It sits on the stimulus side of the detector, driving the detector's x input directly, and reports busy/done to a controller.

Parameters:
CNT_W, 4, width of the frame repeat count.
GAP_W, 4, width of the inter-frame zero-gap length.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request to begin a burst; sampled only in IDLE
repeat_n  input  CNT_W  number of 1101 frames in the burst, captured on accepted start
gap  input  GAP_W  zero bits inserted between frames, captured on accepted start
overlap  input  1  1 = overlapped frames, effective only when gap==0; captured on accepted start
x_out  output  1  serial data bit; forced 0 whenever valid==0
valid  output  1  x_out carries a burst bit this cycle (pattern or gap bit)
busy  output  1  high from the cycle after start is accepted until done, inclusive
done  output  1  one-cycle pulse after the last bit of a burst

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst is high: state=IDLE, counters cleared. Outputs while in reset: x_out=0, valid=0, busy=0, done=0.
- Outputs are decoded from the registered state only (Moore). There is no combinational path from any input to any output.
- States: IDLE, B0 (x=1), B1 (x=1), B2 (x=0), B3 (x=1), GAP (x=0), DONE.
- valid=1 in B0..B3 and GAP. busy=1 in every state except IDLE. done=1 only in DONE.
- IDLE: start=1 at edge t captures repeat_n, gap and overlap into internal registers.
  - repeat_n!=0: go to B0; the first bit appears in the cycle after edge t.
  - repeat_n==0: go directly to DONE; valid never asserts.
- B0 -> B1 -> B2 -> B3 unconditionally. The frame remaining count rem is loaded with repeat_n.
- B3, when rem==1: go to DONE.
- B3, otherwise: decrement rem, then
  - captured gap!=0: go to GAP with gcnt=gap;
  - gap==0 and overlap=1: go to B1, reusing the just-sent 1 as the new frame's first bit;
  - gap==0 and overlap=0: go to B0.
- GAP: decrement gcnt each cycle; go to B0 after exactly gap cycles in GAP.
- DONE: lasts one cycle, then go to IDLE. A new start can be accepted on the edge leaving IDLE, i.e. the earliest is 2 cycles after done.
- Bit counts per burst:
  - non-overlap: 4N + gap*(N-1);
  - overlap with gap==0: 3N+1.
- start while busy: ignored, with no effect on the burst in flight.
- Input changes mid-burst: changes to repeat_n, gap or overlap have no effect.
- Reset mid-burst: immediate return to IDLE and all outputs 0. No done pulse is produced for the aborted burst.
- Count widths: rem is CNT_W bits and gcnt is GAP_W bits. The maximum values (2^CNT_W-1 frames, 2^GAP_W-1 gap) must work without wrap.

Test Plan:
- N=1, gap=0, overlap=0, start pulse at edge 0 -> x_out=1,1,0,1 in cycles 1-4 with valid=1; done=1 in cycle 5; busy cycles 1-5; downstream detector z pulses once.
- N=3, gap=0, overlap=0 -> 110111011101 (12 valid bits), done in cycle 13; detector z count = 3.
- N=3, gap=0, overlap=1 -> 1101101101 (10 valid bits), done in cycle 11; detector z count = 3.
- N=2, gap=2 -> 110100 1101 (10 valid bits, gap bits x_out=0 with valid=1), done in cycle 11. Repeat with overlap=1: identical output, since overlap is ignored when gap!=0.
- N=0 -> done in cycle 1, valid never high, x_out stays 0. N=15, gap=15 -> 270 valid bits with no wrap.
- N=4 burst, rst asserted asynchronously mid-cycle during B2 of frame 2 -> all outputs 0 immediately, no done; new start after reset produces a full burst. start re-pulsed during busy -> no change to the bit sequence.

Source files
------------

// File: rtl/seq_gen_1101.sv
// seq_gen_1101: Moore serial transmitter emitting N frames of 1101, back-to-back,
// overlapped, or separated by a programmable zero gap. Revision 1.0.
`default_nettype none

module seq_gen_1101 #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  input  logic             overlap,
  output logic             x_out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_B0   = 3'd1,
    S_B1   = 3'd2,
    S_B2   = 3'd3,
    S_B3   = 3'd4,
    S_GAP  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rem;
  logic [GAP_W-1:0] gcnt;
  logic [GAP_W-1:0] gap_r;
  logic             ovl_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (repeat_n != '0) ? S_B0 : S_DONE;
      S_B0:   state_nxt = S_B1;
      S_B1:   state_nxt = S_B2;
      S_B2:   state_nxt = S_B3;
      S_B3: begin
        if (rem == CNT_W'(1))  state_nxt = S_DONE;
        else if (gap_r != '0)  state_nxt = S_GAP;
        // Overlap reuses the trailing 1 as the next frame's leading 1.
        else if (ovl_r)        state_nxt = S_B1;
        else                   state_nxt = S_B0;
      end
      S_GAP:  if (gcnt == GAP_W'(1)) state_nxt = S_B0;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Burst parameters are frozen at start so mid-burst input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      gcnt  <= '0;
      gap_r <= '0;
      ovl_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          rem   <= repeat_n;
          gap_r <= gap;
          ovl_r <= overlap;
        end
        S_B3: if (rem != CNT_W'(1)) begin
          rem  <= rem - CNT_W'(1);
          gcnt <= gap_r;
        end
        S_GAP: gcnt <= gcnt - GAP_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    x_out = 1'b0;
    valid = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    case (state)
      S_IDLE: busy = 1'b0;
      S_B0:   begin valid = 1'b1; x_out = 1'b1; end
      S_B1:   begin valid = 1'b1; x_out = 1'b1; end
      S_B2:   valid = 1'b1;
      S_B3:   begin valid = 1'b1; x_out = 1'b1; end
      S_GAP:  valid = 1'b1;
      S_DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

`default_nettype wire
